aes_pipe_sched: RTL and testbench

- Scheduler in front of the fully pipelined masked AES `Cipher` core.
- Accepts 2-share blocks through a valid/ready stream and holds per-mode 2-share round keys.
- Sequences the core's reset/key-load window and enc/dec mode switches, inserting drains and bubbles as needed.
- Tracks in-flight blocks with a tag shift register and emits each result with its tag; one block per clock in steady state.

---
 rtl/aes_sched_pkg.sv | 29 ++
 rtl/aes_sched_track.sv | 34 +++
 rtl/aes_pipe_sched.sv | 183 ++++++++++++++++++
 tb/tb_aes_pipe_sched.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_sched_pkg.sv
// Shared types and sizing for the masked AES pipeline scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package aes_sched_pkg;

  // Core pipeline depth, key-load window and user tag width
  localparam int LATENCY     = 10;
  localparam int LOAD_CYCLES = 24;
  localparam int TAG_W       = 4;

  // In-flight counter must hold 0..LATENCY inclusive
  localparam int CNT_W  = $clog2(LATENCY + 1);
  localparam int LOAD_W = $clog2(LOAD_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DRAIN
  } schedState_t;

  // One slot of the in-flight tracker, aligned with one core pipeline stage
  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic             dec;
  } entry_t;

endpackage

// File: rtl/aes_sched_track.sv
// Tag shift register mirroring the core pipeline, plus an in-flight block counter.
// Latency: an entry pushed on an advancing cycle reaches the tail LATENCY advancing cycles later.
// Backpressure: none; frozen entirely while advance is low.
module aes_sched_track
  import aes_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance,
  input  entry_t           pushEntry,
  output entry_t           tailEntry,
  output logic [CNT_W-1:0] inFlight
);

  entry_t [LATENCY-1:0] stages;

  assign tailEntry = stages[LATENCY-1];

  // Shift one slot per advancing cycle and keep the count of valid slots
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stages   <= '0;
      inFlight <= '0;
    end else if (advance) begin
      stages <= {stages[LATENCY-2:0], pushEntry};
      case ({pushEntry.valid, stages[LATENCY-1].valid})
        2'b10:   inFlight <= inFlight + CNT_W'(1);
        2'b01:   inFlight <= inFlight - CNT_W'(1);
        default: inFlight <= inFlight;
      endcase
    end
  end

endmodule

// File: rtl/aes_pipe_sched.sv
// Scheduler feeding 2-share blocks and 2-share round keys into the pipelined masked AES core.
// Latency: LATENCY+1 cycles from accepted block to out_valid; one block per cycle in steady state.
// Backpressure: in_ready low outside RUN, on mode change or on a pending current-slot key write; results never stall.
module aes_pipe_sched
  import aes_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_valid,
  output logic             key_ready,
  input  logic             key_dec,
  input  logic [127:0]     key0,
  input  logic [127:0]     key1,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_dec,
  input  logic [127:0]     in_data0,
  input  logic [127:0]     in_data1,
  input  logic [TAG_W-1:0] in_tag,
  output logic             cph_rst,
  output logic             cph_dec,
  output logic [127:0]     cph_key0,
  output logic [127:0]     cph_key1,
  output logic [127:0]     cph_data0,
  output logic [127:0]     cph_data1,
  input  logic [127:0]     cph_out0,
  input  logic [127:0]     cph_out1,
  input  logic             cph_done,
  output logic             out_valid,
  output logic [127:0]     out_data0,
  output logic [127:0]     out_data1,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_dec,
  output logic             busy,
  output logic             err
);

  schedState_t        state;
  logic [LOAD_W-1:0]  loadCnt;
  logic               curDec;

  // Key slots, indexed by mode; shares are stored and forwarded separately
  logic [1:0][127:0]  slotKey0;
  logic [1:0][127:0]  slotKey1;
  logic [1:0]         slotVld;

  logic               curKeyWr;
  logic               modeSwitch;
  logic               accept;
  logic               keyWr;
  logic               advance;
  logic               tailHit;
  entry_t             pushEntry;
  entry_t             tailEntry;
  logic [CNT_W-1:0]   inFlight;

  assign curKeyWr   = key_valid && (key_dec == curDec);
  assign modeSwitch = in_valid && (in_dec != curDec);
  assign in_ready   = (state == RUN) && !curKeyWr && (!in_valid || (in_dec == curDec));
  assign accept     = in_valid && in_ready;
  assign keyWr      = key_valid && key_ready;
  assign advance    = (state == RUN) || (state == DRAIN);
  assign tailHit    = advance && tailEntry.valid;
  assign busy       = (state != IDLE) || (inFlight != '0);

  assign cph_dec    = curDec;
  assign cph_key0   = slotKey0[curDec];
  assign cph_key1   = slotKey1[curDec];
  assign cph_data0  = accept ? in_data0 : '0;
  assign cph_data1  = accept ? in_data1 : '0;

  // The active slot is locked while it is being loaded or drained out of the core
  always_comb begin
    key_ready = 1'b1;
    if (((state == LOAD) || (state == DRAIN)) && (key_dec == curDec)) begin
      key_ready = 1'b0;
    end
  end

  // Accepted blocks enter the tracker as valid entries, everything else is a bubble
  always_comb begin
    pushEntry = '0;
    if (accept) begin
      pushEntry.valid = 1'b1;
      pushEntry.tag   = in_tag;
      pushEntry.dec   = curDec;
    end
  end

  // Key share storage; writes land in the slot named by key_dec
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slotKey0 <= '0;
      slotKey1 <= '0;
      slotVld  <= '0;
    end else if (keyWr) begin
      slotKey0[key_dec] <= key0;
      slotKey1[key_dec] <= key1;
      slotVld[key_dec]  <= 1'b1;
    end
  end

  // Core sequencing: idle, key-load window, streaming, drain before reload
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      loadCnt <= '0;
      curDec  <= 1'b0;
      cph_rst <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          cph_rst <= 1'b1;
          if (in_valid && slotVld[in_dec]) begin
            curDec  <= in_dec;
            loadCnt <= '0;
            state   <= LOAD;
          end
        end
        LOAD: begin
          if (loadCnt == LOAD_W'(LOAD_CYCLES - 1)) begin
            state   <= RUN;
            cph_rst <= 1'b0;
          end else begin
            loadCnt <= loadCnt + LOAD_W'(1);
          end
        end
        RUN: begin
          if (modeSwitch || curKeyWr) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (inFlight == '0) begin
            cph_rst <= 1'b1;
            if (in_valid && slotVld[in_dec]) begin
              curDec  <= in_dec;
              loadCnt <= '0;
              state   <= LOAD;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state   <= IDLE;
          cph_rst <= 1'b1;
        end
      endcase
    end
  end

  // Register the core result the cycle after its tracker entry reaches the tail
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data0 <= '0;
      out_data1 <= '0;
      out_tag   <= '0;
      out_dec   <= 1'b0;
      err       <= 1'b0;
    end else begin
      out_valid <= tailHit;
      out_data0 <= tailHit ? cph_out0 : '0;
      out_data1 <= tailHit ? cph_out1 : '0;
      out_tag   <= tailHit ? tailEntry.tag : '0;
      out_dec   <= tailHit && tailEntry.dec;
      if (tailHit && !cph_done) begin
        err <= 1'b1;
      end
    end
  end

  aes_sched_track uTrack (
    .clk       (clk),
    .rst_n     (rst_n),
    .advance   (advance),
    .pushEntry (pushEntry),
    .tailEntry (tailEntry),
    .inFlight  (inFlight)
  );

endmodule

// File: tb/tb_aes_pipe_sched.sv
// Bench for aes_pipe_sched with a share-linear stand-in for the masked cipher core.
// Latency: results expected exactly LATENCY+1 cycles after each accepted block.
// Backpressure: drives valid/ready stimulus and tracks accepted blocks in a scoreboard queue.
module tb_aes_pipe_sched;
  import aes_sched_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             key_valid = 1'b0;
  logic             key_ready;
  logic             key_dec = 1'b0;
  logic [127:0]     key0 = '0;
  logic [127:0]     key1 = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             in_dec = 1'b0;
  logic [127:0]     in_data0 = '0;
  logic [127:0]     in_data1 = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             cph_rst;
  logic             cph_dec;
  logic [127:0]     cph_key0, cph_key1, cph_data0, cph_data1;
  logic [127:0]     cph_out0, cph_out1;
  logic             cph_done;
  logic             out_valid;
  logic [127:0]     out_data0, out_data1;
  logic [TAG_W-1:0] out_tag;
  logic             out_dec;
  logic             busy;
  logic             err;

  always #5 clk = ~clk;

  aes_pipe_sched dut (
    .clk(clk), .rst_n(rst_n),
    .key_valid(key_valid), .key_ready(key_ready), .key_dec(key_dec), .key0(key0), .key1(key1),
    .in_valid(in_valid), .in_ready(in_ready), .in_dec(in_dec),
    .in_data0(in_data0), .in_data1(in_data1), .in_tag(in_tag),
    .cph_rst(cph_rst), .cph_dec(cph_dec), .cph_key0(cph_key0), .cph_key1(cph_key1),
    .cph_data0(cph_data0), .cph_data1(cph_data1), .cph_out0(cph_out0), .cph_out1(cph_out1),
    .cph_done(cph_done),
    .out_valid(out_valid), .out_data0(out_data0), .out_data1(out_data1),
    .out_tag(out_tag), .out_dec(out_dec), .busy(busy), .err(err)
  );

  // Stand-in cipher: linear over XOR, so it acts share-wise like a masked core
  function automatic logic [127:0] mix(input logic [127:0] x, input logic dec);
    return dec ? {x[120:0], x[127:121]} : {x[98:0], x[127:99]};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Core model: latches key and mode while held in reset, then a fixed-depth pipe
  logic                      holdDoneLow = 1'b0;
  logic [LATENCY-1:0][127:0] cS0, cS1;
  logic [LATENCY-1:0]        cV = '0;
  logic [127:0]              cKey0, cKey1;
  logic                      cDec;

  always @(posedge clk) begin
    if (cph_rst) begin
      cKey0 <= cph_key0;
      cKey1 <= cph_key1;
      cDec  <= cph_dec;
      cV    <= '0;
    end else begin
      cS0 <= {cS0[LATENCY-2:0], mix(cph_data0 ^ cKey0, cDec)};
      cS1 <= {cS1[LATENCY-2:0], mix(cph_data1 ^ cKey1, cDec)};
      cV  <= {cV[LATENCY-2:0], 1'b1};
    end
  end

  assign cph_out0 = cS0[LATENCY-1];
  assign cph_out1 = cS1[LATENCY-1];
  assign cph_done = cV[LATENCY-1] && !holdDoneLow;

  // Reference model state
  typedef struct {
    logic [127:0]     res;
    logic [TAG_W-1:0] tag;
    logic             dec;
    int               due;
  } exp_t;

  exp_t         expQ[$];
  logic [127:0] keyMdl0[2];
  logic [127:0] keyMdl1[2];
  int           cyc = 0;
  int           nChecks = 0;
  int           nPass = 0;
  logic         accNow = 1'b0;
  logic         sInReady, sKeyReady, sErr, sCphRst, sBusy;

  task automatic checkVal(input string tag, input logic [127:0] got, input logic [127:0] want);
    nChecks++;
    if (got === want) begin
      nPass++;
    end else begin
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // One clock: sample just before the rising edge, update the model, return at the next falling edge
  task automatic step();
    exp_t e;
    #4;
    cyc++;
    sInReady  = in_ready;
    sKeyReady = key_ready;
    sErr      = err;
    sCphRst   = cph_rst;
    sBusy     = busy;
    accNow    = in_valid && in_ready;
    if (accNow) begin
      e.res = mix(in_data0 ^ in_data1 ^ keyMdl0[in_dec] ^ keyMdl1[in_dec], in_dec);
      e.tag = in_tag;
      e.dec = in_dec;
      e.due = cyc + LATENCY + 1;
      expQ.push_back(e);
    end
    if (key_valid && key_ready) begin
      keyMdl0[key_dec] = key0;
      keyMdl1[key_dec] = key1;
    end
    if (out_valid) begin
      if (expQ.size() == 0) begin
        checkVal("spuriousOut", out_valid, 1'b0);
      end else begin
        e = expQ.pop_front();
        checkVal("outData", out_data0 ^ out_data1, e.res);
        checkVal("outTag", out_tag, e.tag);
        checkVal("outDec", out_dec, e.dec);
        checkVal("outCycle", cyc, e.due);
      end
    end else if (expQ.size() > 0 && expQ[0].due <= cyc) begin
      checkVal("outMissing", out_valid, 1'b1);
      void'(expQ.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid  = 1'b0;
    key_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic writeKey(input logic dec, input logic [127:0] k, input logic [127:0] m);
    key_valid = 1'b1;
    key_dec   = dec;
    key0      = k ^ m;
    key1      = m;
    step();
    checkVal("keyAccepted", sKeyReady, 1'b1);
    key_valid = 1'b0;
  endtask

  task automatic sendBlk(input logic dec, input logic [127:0] d, input logic [127:0] m,
                         input logic [TAG_W-1:0] tag, output int offC, output int accC);
    in_valid = 1'b1;
    in_dec   = dec;
    in_data0 = d ^ m;
    in_data1 = m;
    in_tag   = tag;
    offC     = cyc + 1;
    accC     = -1;
    for (int n = 0; n < 200 && accC < 0; n++) begin
      step();
      if (accNow) accC = cyc;
    end
    if (accC < 0) checkVal("acceptTimeout", sInReady, 1'b1);
  endtask

  logic [127:0] blk[4];
  int           offC, accC, acc[4], accA, accB, wCyc;
  logic         curD;

  initial begin
    blk[0] = 128'h340737e0a29831318d305a88a8f64332;
    blk[1] = 128'h0;
    blk[2] = 128'h0123456789abcdef0123456789abcdef;
    blk[3] = 128'h00112233445566778899aabbccddeeff;
    for (int i = 0; i < 2; i++) begin
      keyMdl0[i] = '0;
      keyMdl1[i] = '0;
    end

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    checkVal("rstCphRst", cph_rst, 1'b1);
    checkVal("rstCphDec", cph_dec, 1'b0);
    checkVal("rstKeyReady", key_ready, 1'b1);
    checkVal("rstInReady", in_ready, 1'b0);
    checkVal("rstOutValid", out_valid, 1'b0);
    checkVal("rstErr", err, 1'b0);
    checkVal("rstBusy", busy, 1'b0);
    checkVal("rstOutData", out_data0 | out_data1, 128'h0);
    checkVal("rstCphKey", cph_key0 | cph_key1, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Encryption key, four back-to-back blocks after the load window
    writeKey(1'b0, 128'h3c4fcf098815f7aba6d2ae2816157e2b, 128'h0);
    for (int i = 0; i < 4; i++) begin
      sendBlk(1'b0, blk[i], 128'h0, TAG_W'(i), offC, acc[i]);
      if (i == 0) checkVal("loadWindow", acc[0] - offC, LOAD_CYCLES + 1);
      else checkVal("backToBack", acc[i] - acc[i-1], 1);
    end
    idle(LATENCY + 3);
    checkVal("drainedT1", expQ.size(), 0);

    // Write to the idle slot while streaming encryption: no drain
    key_valid = 1'b1;
    key_dec   = 1'b1;
    key0      = 128'ha60c63b6c80c3fe18925eec9a8f914d0;
    key1      = 128'h0;
    step();
    checkVal("otherSlotKeyReady", sKeyReady, 1'b1);
    checkVal("otherSlotInReady", sInReady, 1'b1);
    key_valid = 1'b0;
    step();
    checkVal("stillRunning", sInReady, 1'b1);

    // Decryption block right behind encryption traffic: drain then reload
    sendBlk(1'b0, blk[2], rnd128(), 4'd4, offC, accA);
    sendBlk(1'b0, blk[3], rnd128(), 4'd5, offC, accA);
    sendBlk(1'b1, 128'h320b6a19978511dcfb09dc021d842539, rnd128(), 4'd6, offC, accB);
    checkVal("drainReload", accB - accA, LATENCY + LOAD_CYCLES + 2);

    // Gap between accepts becomes bubbles in the output stream
    sendBlk(1'b1, rnd128(), rnd128(), 4'd7, offC, accA);
    idle(3);
    sendBlk(1'b1, rnd128(), rnd128(), 4'd8, offC, accB);
    checkVal("gapAccept", accB - accA, 4);
    idle(LATENCY + 3);
    checkVal("drainedT4", expQ.size(), 0);

    // Current-slot key write beats a block in the same cycle
    key_valid = 1'b1;
    key_dec   = 1'b1;
    key1      = rnd128();
    key0      = rnd128();
    in_valid  = 1'b1;
    in_dec    = 1'b1;
    in_data0  = rnd128();
    in_data1  = rnd128();
    in_tag    = 4'd9;
    step();
    wCyc = cyc;
    checkVal("keyPrioInReady", sInReady, 1'b0);
    checkVal("keyPrioKeyReady", sKeyReady, 1'b1);
    key_valid = 1'b0;
    sendBlk(1'b1, rnd128(), rnd128(), 4'd9, offC, accA);
    checkVal("keyReload", accA - wCyc, LOAD_CYCLES + 2);

    // Other-slot key write together with a block: both accepted
    key_valid = 1'b1;
    key_dec   = 1'b0;
    key0      = rnd128();
    key1      = rnd128();
    in_valid  = 1'b1;
    in_dec    = 1'b1;
    in_tag    = 4'd10;
    step();
    checkVal("dualInReady", sInReady, 1'b1);
    checkVal("dualKeyReady", sKeyReady, 1'b1);
    idle(LATENCY + 3);

    // Randomised masked traffic with mode switches and key rewrites
    curD = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(15) == 0) curD = ~curD;
      in_valid  = ($urandom_range(3) != 0);
      in_dec    = curD;
      in_data0  = rnd128();
      in_data1  = rnd128();
      in_tag    = TAG_W'($urandom());
      key_valid = ($urandom_range(31) == 0);
      key_dec   = 1'($urandom_range(1));
      key0      = rnd128();
      key1      = rnd128();
      step();
    end
    idle(LATENCY + 3 + LOAD_CYCLES);
    checkVal("drainedRandom", expQ.size(), 0);
    checkVal("noErrRandom", sErr, 1'b0);

    // Reset in the middle of a stream
    in_valid = 1'b1;
    in_dec   = curD;
    repeat (6) step();
    rst_n = 1'b0;
    #1;
    checkVal("midRstOutValid", out_valid, 1'b0);
    checkVal("midRstCphRst", cph_rst, 1'b1);
    checkVal("midRstInReady", in_ready, 1'b0);
    checkVal("midRstBusy", busy, 1'b0);
    expQ.delete();
    @(negedge clk);
    rst_n  = 1'b1;
    in_dec = 1'b0;
    repeat (30) step();
    checkVal("noKeyCphRst", sCphRst, 1'b1);
    checkVal("noKeyInReady", sInReady, 1'b0);
    checkVal("noKeyBusy", sBusy, 1'b0);

    // Core done held low: err sets on the first tail and sticks
    holdDoneLow = 1'b1;
    in_valid    = 1'b0;
    writeKey(1'b0, rnd128(), rnd128());
    sendBlk(1'b0, rnd128(), rnd128(), 4'd11, offC, accA);
    in_valid = 1'b0;
    for (int n = 0; n < 100 && cyc < accA + LATENCY; n++) step();
    checkVal("errBeforeTail", sErr, 1'b0);
    step();
    checkVal("errAtTail", sErr, 1'b1);
    idle(3);
    checkVal("errSticky", sErr, 1'b1);
    holdDoneLow = 1'b0;

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
